// File: rtl/temp_window_accumulator.sv
// rtl/temp_window_accumulator.sv - windowed temperature sum/min/max feeding a combinational divider
module temp_window_accumulator #(
    parameter int DATA_W  = 12,
    parameter int WIN_MAX = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              sample_ready,
    input  logic [CNT_W-1:0]  win_len,
    input  logic              flush,
    output logic [15:0]       div_n,
    output logic [15:0]       div_d,
    output logic [DATA_W-1:0] win_min,
    output logic [DATA_W-1:0] win_max,
    output logic              div_valid,
    input  logic              div_ack,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         sum_q, sum_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   min_q, min_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic [15:0]         div_n_q, div_n_d;
    logic [15:0]         div_d_q, div_d_d;
    logic [DATA_W-1:0]   win_min_q, win_min_d;
    logic [DATA_W-1:0]   win_max_q, win_max_d;

    logic                accept;
    logic                close;
    logic [CNT_W-1:0]    eff_len;
    logic [15:0]         sample_ext;

    assign sample_ready = (state_q != PRESENT);
    assign busy         = (state_q == ACCUM);
    assign div_valid    = (state_q == PRESENT);
    assign div_n        = div_n_q;
    assign div_d        = div_d_q;
    assign win_min      = win_min_q;
    assign win_max      = win_max_q;

    assign accept     = sample_valid && sample_ready;
    assign sample_ext = {{(16-DATA_W){1'b0}}, sample_data};

    always_comb begin
        eff_len = win_len;
        if (win_len == '0) begin
            eff_len = CNT_W'(1);
        end else if (win_len > CNT_W'(WIN_MAX)) begin
            eff_len = CNT_W'(WIN_MAX);
        end
    end

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        count_d   = count_q;
        len_d     = len_q;
        min_d     = min_q;
        max_d     = max_q;
        div_n_d   = div_n_q;
        div_d_d   = div_d_q;
        win_min_d = win_min_q;
        win_max_d = win_max_q;
        close     = 1'b0;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    sum_d   = sum_q + sample_ext;
                    count_d = count_q + CNT_W'(1);
                    min_d   = (sample_data < min_q) ? sample_data : min_q;
                    max_d   = (sample_data > max_q) ? sample_data : max_q;
                end
                // A flush on the same edge as a sample closes the window after including it.
                close = (accept && (count_d == len_q)) || flush;
            end
            PRESENT: begin
                if (div_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                // IDLE and the unused encoding both behave as IDLE.
                state_d = IDLE;
                if (accept) begin
                    sum_d   = sample_ext;
                    count_d = CNT_W'(1);
                    min_d   = sample_data;
                    max_d   = sample_data;
                    len_d   = eff_len;
                    if ((eff_len == CNT_W'(1)) || flush) begin
                        close = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
        endcase

        if (close) begin
            state_d   = PRESENT;
            div_n_d   = sum_d;
            div_d_d   = {{(16-CNT_W){1'b0}}, count_d};
            win_min_d = min_d;
            win_max_d = max_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sum_q     <= '0;
            count_q   <= '0;
            len_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            div_n_q   <= '0;
            div_d_q   <= '0;
            win_min_q <= '0;
            win_max_q <= '0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            count_q   <= count_d;
            len_q     <= len_d;
            min_q     <= min_d;
            max_q     <= max_d;
            div_n_q   <= div_n_d;
            div_d_q   <= div_d_d;
            win_min_q <= win_min_d;
            win_max_q <= win_max_d;
        end
    end

endmodule

// File: tb/tb_temp_window_accumulator.sv
// tb/tb_temp_window_accumulator.sv - scoreboard bench for temp_window_accumulator
module tb_temp_window_accumulator;

    localparam int DATA_W  = 12;
    localparam int WIN_MAX = 16;
    localparam int CNT_W   = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] sample_data = '0;
    logic              sample_ready;
    logic [CNT_W-1:0]  win_len = '0;
    logic              flush = 1'b0;
    logic [15:0]       div_n;
    logic [15:0]       div_d;
    logic [DATA_W-1:0] win_min;
    logic [DATA_W-1:0] win_max;
    logic              div_valid;
    logic              div_ack = 1'b0;
    logic              busy;

    temp_window_accumulator #(
        .DATA_W (DATA_W),
        .WIN_MAX(WIN_MAX),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .sample_ready(sample_ready),
        .win_len     (win_len),
        .flush       (flush),
        .div_n       (div_n),
        .div_d       (div_d),
        .win_min     (win_min),
        .win_max     (win_max),
        .div_valid   (div_valid),
        .div_ack     (div_ack),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int d;
        int mn;
        int mx;
    } exp_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t cur;
    int   m_win[$];
    int   m_len;
    bit   m_open;
    bit   m_present;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int clamp_len(input int w);
        if (w == 0) return 1;
        if (w > WIN_MAX) return WIN_MAX;
        return w;
    endfunction

    task automatic model_reset();
        m_win.delete();
        exp_q.delete();
        m_open    = 0;
        m_present = 0;
        m_len     = 0;
    endtask

    // Window semantics at transaction level: a list of samples closed by length or flush.
    task automatic model_step();
        exp_t e;
        if (m_present) begin
            if (div_ack) m_present = 0;
        end else begin
            if (sample_valid) begin
                if (!m_open) begin
                    m_win.delete();
                    m_len  = clamp_len(int'(win_len));
                    m_open = 1;
                end
                m_win.push_back(int'(sample_data));
            end
            if (m_open && (m_win.size() == m_len || flush)) begin
                e.n  = 0;
                e.mn = 4096;
                e.mx = -1;
                foreach (m_win[i]) begin
                    e.n += m_win[i];
                    if (m_win[i] < e.mn) e.mn = m_win[i];
                    if (m_win[i] > e.mx) e.mx = m_win[i];
                end
                e.d = m_win.size();
                exp_q.push_back(e);
                m_open    = 0;
                m_present = 1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic send(input int data);
        sample_valid = 1'b1;
        sample_data  = DATA_W'(data);
        cycle();
        sample_valid = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic ack();
        div_ack = 1'b1;
        cycle();
        div_ack = 1'b0;
    endtask

    // Monitor: flow-control against the model every cycle, payload against the scoreboard.
    initial begin
        bit prev_valid;
        prev_valid = 0;
        forever begin
            @(negedge clk);
            chk("sample_ready", int'(sample_ready), int'(!m_present));
            chk("busy", int'(busy), int'(m_open));
            chk("div_valid", int'(div_valid), int'(m_present));
            if (div_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL window_pop: div_valid rose with empty scoreboard at %0t", $time);
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            if (div_valid) begin
                chk("div_n", int'(div_n), cur.n);
                chk("div_d", int'(div_d), cur.d);
                chk("win_min", int'(win_min), cur.mn);
                chk("win_max", int'(win_max), cur.mx);
                chk("div_d_range", int'(div_d >= 16'd1 && div_d <= 16'(WIN_MAX)), 1);
            end
            prev_valid = div_valid;
        end
    end

    initial begin
        model_reset();
        #12;
        chk("rst_div_n", int'(div_n), 0);
        chk("rst_div_d", int'(div_d), 0);
        chk("rst_win_min", int'(win_min), 0);
        chk("rst_win_max", int'(win_max), 0);
        chk("rst_div_valid", int'(div_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sample_ready", int'(sample_ready), 1);
        rst_n = 1'b1;
        cycle();

        // Full window of four
        win_len = 5'd4;
        send(100); send(200); send(300);
        chk("full_early_valid", int'(div_valid), 0);
        send(400);
        chk("full_valid", int'(div_valid), 1);
        chk("full_n", int'(div_n), 1000);
        chk("full_d", int'(div_d), 4);
        chk("full_min", int'(win_min), 100);
        chk("full_max", int'(win_max), 400);
        chk("full_q", int'(div_n / div_d), 250);
        chk("full_r", int'(div_n % div_d), 0);
        ack();
        chk("full_ack_drop", int'(div_valid), 0);

        // Length clamping and maximum sum
        win_len = 5'd0;
        send(4095);
        chk("clamp0_n", int'(div_n), 4095);
        chk("clamp0_d", int'(div_d), 1);
        ack();
        win_len = 5'd31;
        for (int i = 0; i < 15; i++) send(4095);
        chk("clamp31_early", int'(div_valid), 0);
        send(4095);
        chk("clamp31_n", int'(div_n), 65520);
        chk("clamp31_d", int'(div_d), 16);
        ack();

        // Flush with the last sample, then flush alone in IDLE
        win_len = 5'd8;
        send(10); send(30);
        flush = 1'b1;
        send(20);
        chk("flush_n", int'(div_n), 60);
        chk("flush_d", int'(div_d), 3);
        chk("flush_min", int'(win_min), 10);
        chk("flush_max", int'(win_max), 30);
        ack();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        chk("idle_flush_valid", int'(div_valid), 0);

        // Backpressure, then a length change mid-window
        win_len = 5'd2;
        send(5); send(7);
        win_len      = 5'd4;
        sample_valid = 1'b1;
        sample_data  = 12'd99;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("bp_ready", int'(sample_ready), 0);
            chk("bp_n", int'(div_n), 12);
        end
        div_ack = 1'b1;
        cycle();
        div_ack = 1'b0;
        chk("bp_ack_drop", int'(div_valid), 0);
        chk("bp_not_taken", int'(busy), 0);
        cycle();
        chk("bp_taken", int'(busy), 1);
        sample_valid = 1'b0;
        win_len = 5'd2;
        send(1);
        chk("len_hold_open", int'(div_valid), 0);
        send(2); send(3);
        chk("len_hold_d", int'(div_d), 4);
        chk("len_hold_n", int'(div_n), 105);
        ack();

        // Asynchronous reset in the middle of a window
        win_len = 5'd8;
        send(1); send(2); send(3);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_valid", int'(div_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(sample_ready), 1);
        cycle();
        rst_n = 1'b1;
        win_len = 5'd2;
        send(50); send(60);
        chk("fresh_n", int'(div_n), 110);
        chk("fresh_d", int'(div_d), 2);
        ack();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            sample_valid = ($urandom_range(0, 3) != 0);
            sample_data  = DATA_W'($urandom_range(0, 4095));
            win_len      = CNT_W'($urandom_range(0, 31));
            flush        = m_open && ($urandom_range(0, 7) == 0);
            div_ack      = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #2;
                rst_n = 1'b1;
            end
            cycle();
        end

        // Drain any window still open or presented
        sample_valid = 1'b0;
        div_ack      = 1'b0;
        flush        = 1'b1;
        cycle();
        flush   = 1'b0;
        div_ack = 1'b1;
        cycle();
        cycle();
        div_ack = 1'b0;
        cycle();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
